fcims_payment_collector: RTL and testbench
==========================================

Name: fcims_payment_collector

Overview:
- Sequential customer-side counterpart to the FCIMS billing datapath: it takes the 8-bit total price produced by the pricing adder and collects coins against it.
- On completion it returns either a change amount (bill paid) or a full refund (cancel or timeout).
- Sits between the FCIMS price output and the till/coin hardware.
- Arithmetic stays ripple-style, consistent with the existing adder cells.

Parameters:
- WIDTH, 8, bill width; matches the FCIMS total-price bus.
- COIN_W, 4, coin value width; coin values are 0..15.
- TIMEOUT, 200, idle cycles in COLLECT before auto-refund; legal range 2..2^16-1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- bill_valid  in  1  bill offered.
- bill_ready  out  1  collector can accept a bill.
- bill_amount  in  WIDTH  total price to collect.
- coin_valid  in  1  coin inserted this cycle.
- coin_ready  out  1  coin accepted when high with coin_valid.
- coin_value  in  COIN_W  value of the inserted coin.
- cancel  in  1  customer abort request.
- res_valid  out  1  result available.
- res_ready  in  1  downstream takes the result.
- res_paid  out  1  1 = bill settled with change, 0 = refund.
- res_amount  out  WIDTH+1  change or refund value.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, bill_ready=1, coin_ready=0, res_valid=0, res_paid=0, res_amount=0, busy=0. Internal bill, collected and timer registers clear to 0.
- States: IDLE, COLLECT, CHANGE, REFUND.
- IDLE:
  - bill_ready=1.
  - bill_valid&bill_ready latches bill_amount and clears collected and timer.
  - If bill_amount==0, next state is CHANGE with amount 0; otherwise next state is COLLECT.
  - coin_valid and cancel are ignored in IDLE.
- COLLECT:
  - coin_ready=1; bill_ready=0.
  - Accepted coin: collected_next = collected + coin_value, computed at WIDTH+1 bits with no overflow possible.
  - Nonzero coin: clears the timer. A zero-value coin is accepted but neither changes collected nor clears the timer.
  - collected_next >= bill: next state is CHANGE, and res_amount = collected_next - bill is registered. This value is always < 2^COIN_W.
  - cancel=1: next state is REFUND with res_amount = collected_next. A coin in the same cycle is counted and refunded. Cancel beats payment completion in the same cycle.
  - Timer: increments each cycle without a nonzero coin. When it reaches TIMEOUT-1 with no coin or cancel, next state is REFUND with res_amount = collected. A nonzero coin in that same cycle wins over the timeout.
- CHANGE:
  - res_valid=1, res_paid=1, res_amount held stable.
  - res_ready high: next state is IDLE, and res_valid drops on the following cycle.
  - coin_ready=0.
- REFUND:
  - Same handshake as CHANGE with res_paid=0.
  - Refund of 0 is legal (cancel before any coin).
- Latency:
  - Bill accept to COLLECT: 1 cycle.
  - Final coin to res_valid: 1 cycle.
  - res_valid may be held indefinitely; outputs must not change while res_valid & !res_ready.
- cancel outside COLLECT is ignored.
- Reset asserted mid-operation: immediate return to reset values. The collected amount is discarded; no refund is issued.
- Outputs res_valid, res_paid and res_amount come straight from registers; bill_ready, coin_ready and busy are decoded from state only.

Decomposition:
- Shared package fcims_pkg holds:
  - state encoding constants (IDLE=2'd0, COLLECT=2'd1, CHANGE=2'd2, REFUND=2'd3);
  - FCIMS_PRICE_W=8;
  - FCIMS_COIN_W=4.
- One natural sub-module: fcims_cmp_sub. It is a WIDTH+1 ripple subtractor that outputs the difference plus a "borrow-free" flag, which gives the >= decision. It is reused for the change computation.

Test Plan:
- Exact pay: bill 25, coins 10,10,5 -> res_valid 1 cycle after the third coin, res_paid=1, res_amount=0; back in IDLE one cycle after res_ready.
- Overpay: bill 200, coins 15 x13 (195) then 15 -> res_paid=1, res_amount=10; a coin offered during CHANGE sees coin_ready=0.
- Cancel with coin in the same cycle: bill 50, coins 7,8, then cancel with coin 9 -> res_paid=0, res_amount=24.
- Timeout: TIMEOUT=20, bill 30, coin 12, then idle 19 cycles -> REFUND, res_amount=12. Repeat with a zero-value coin at cycle 10 -> the timeout still fires at the same cycle.
- Zero bill and backpressure: bill 0 -> CHANGE with amount 0. Hold res_ready=0 for 5 cycles -> outputs stable, bill_ready=0 throughout.
- Async reset mid-COLLECT: bill 90, coin 15, pulse reset_n low between edges -> all outputs at reset values immediately, no res_valid; a new bill 5 then completes normally.

Source files
------------

// File: rtl/fcims_pkg.sv
// Shared FCIMS constants: bus widths and the payment collector state encoding.
package fcims_pkg;

    // Total-price bus width produced by the FCIMS pricing adder.
    localparam int FCIMS_PRICE_W = 8;

    // Coin value width; coins are worth 0..15.
    localparam int FCIMS_COIN_W = 4;

    // Idle timer width; covers the full legal TIMEOUT range up to 2^16-1.
    localparam int FCIMS_TIMER_W = 16;

    // Collector state encoding, kept as plain constants so legacy tools can read it.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_CHANGE  = 2'd2;
    localparam logic [1:0] ST_REFUND  = 2'd3;

endpackage : fcims_pkg

// File: rtl/fcims_cmp_sub.sv
// Ripple-borrow subtractor: diff = a - b, plus a flag that is high when a >= b.
// Built from the same full-subtractor cell style as the FCIMS adder chain.
module fcims_cmp_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         no_borrow_o
);

    // borrow[i] is the borrow into bit i; the LSB has no incoming borrow.
    logic [W:0] borrow;

    assign borrow[0] = 1'b0;

    // One full-subtractor cell per bit, chained LSB to MSB.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign diff_o[i]     = a_i[i] ^ b_i[i] ^ borrow[i];
        assign borrow[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow[i]);
    end

    // No borrow out of the MSB means the unsigned difference is non-negative.
    assign no_borrow_o = ~borrow[W];

endmodule : fcims_cmp_sub

// File: rtl/fcims_payment_collector.sv
// FCIMS payment collector: accepts a bill total, collects coins against it and
// returns either change (bill settled) or a full refund (cancel or idle timeout).
module fcims_payment_collector
    import fcims_pkg::*;
#(
    parameter int WIDTH   = FCIMS_PRICE_W,
    parameter int COIN_W  = FCIMS_COIN_W,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bill_valid,
    output logic             bill_ready,
    input  logic [WIDTH-1:0] bill_amount,
    input  logic             coin_valid,
    output logic             coin_ready,
    input  logic [COIN_W-1:0] coin_value,
    input  logic             cancel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_paid,
    output logic [WIDTH:0]   res_amount,
    output logic             busy
);

    // Collected sum and results carry one extra bit so a full bill plus one
    // coin never wraps.
    localparam int RW      = WIDTH + 1;
    localparam int TIMER_W = FCIMS_TIMER_W;

    // Timer value at which an idle COLLECT cycle turns into a refund.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   bill_q, bill_d;
    logic [RW-1:0]      collected_q, collected_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               res_valid_q, res_valid_d;
    logic               res_paid_q, res_paid_d;
    logic [RW-1:0]      res_amount_q, res_amount_d;

    logic               coin_fire;
    logic               coin_nonzero;
    logic [RW-1:0]      coin_add;
    logic [RW-1:0]      collected_next;
    logic [RW-1:0]      change_amount;
    logic               bill_covered;

    // Handshake and status outputs depend on state alone.
    assign bill_ready = (state_q == ST_IDLE);
    assign coin_ready = (state_q == ST_COLLECT);
    assign busy       = (state_q != ST_IDLE);

    // Result outputs are driven straight from registers so they cannot glitch
    // while a result waits for res_ready.
    assign res_valid  = res_valid_q;
    assign res_paid   = res_paid_q;
    assign res_amount = res_amount_q;

    // Running total including this cycle's coin; a zero coin adds nothing.
    assign coin_fire      = coin_valid & coin_ready;
    assign coin_nonzero   = coin_fire & (coin_value != '0);
    assign coin_add       = coin_fire ? RW'(coin_value) : '0;
    assign collected_next = collected_q + coin_add;

    // Shared subtractor gives both the "paid enough" decision and the change.
    fcims_cmp_sub #(
        .W (RW)
    ) u_cmp_sub (
        .a_i         (collected_next),
        .b_i         (RW'(bill_q)),
        .diff_o      (change_amount),
        .no_borrow_o (bill_covered)
    );

    // Next-state and datapath decode for the collector FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block from inferring latches.
        state_d      = state_q;
        bill_d       = bill_q;
        collected_d  = collected_q;
        timer_d      = timer_q;
        res_valid_d  = res_valid_q;
        res_paid_d   = res_paid_q;
        res_amount_d = res_amount_q;

        case (state_q)
            ST_IDLE: begin
                if (bill_valid) begin
                    bill_d      = bill_amount;
                    collected_d = '0;
                    timer_d     = '0;
                    if (bill_amount == '0) begin
                        // Nothing to collect: settle at once with zero change.
                        state_d      = ST_CHANGE;
                        res_valid_d  = 1'b1;
                        res_paid_d   = 1'b1;
                        res_amount_d = '0;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end

            ST_COLLECT: begin
                collected_d = collected_next;
                // Only real money restarts the idle timer.
                timer_d = coin_nonzero ? '0 : timer_q + TIMER_W'(1);

                if (cancel) begin
                    // Cancel wins over payment; a same-cycle coin is refunded too.
                    state_d      = ST_REFUND;
                    res_valid_d  = 1'b1;
                    res_paid_d   = 1'b0;
                    res_amount_d = collected_next;
                end else if (bill_covered) begin
                    state_d      = ST_CHANGE;
                    res_valid_d  = 1'b1;
                    res_paid_d   = 1'b1;
                    res_amount_d = change_amount;
                end else if (!coin_nonzero && (timer_q == TIMER_LAST)) begin
                    state_d      = ST_REFUND;
                    res_valid_d  = 1'b1;
                    res_paid_d   = 1'b0;
                    res_amount_d = collected_q;
                end
            end

            ST_CHANGE, ST_REFUND: begin
                // Result is held until downstream takes it.
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any collected amount.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bill_q       <= '0;
            collected_q  <= '0;
            timer_q      <= '0;
            res_valid_q  <= 1'b0;
            res_paid_q   <= 1'b0;
            res_amount_q <= '0;
        end else begin
            state_q      <= state_d;
            bill_q       <= bill_d;
            collected_q  <= collected_d;
            timer_q      <= timer_d;
            res_valid_q  <= res_valid_d;
            res_paid_q   <= res_paid_d;
            res_amount_q <= res_amount_d;
        end
    end

endmodule : fcims_payment_collector

// File: tb/tb_fcims_payment_collector.sv
// Scoreboard bench for fcims_payment_collector: scenarios push the expected
// {paid, amount} when they start a transaction; a monitor pops and compares on
// every result handshake. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge or right after the driving edge.
module tb_fcims_payment_collector;

    localparam int WIDTH   = 8;
    localparam int COIN_W  = 4;
    localparam int TIMEOUT = 20;

    typedef logic [WIDTH+1:0] exp_t;  // {paid, amount[WIDTH:0]}

    logic              clk = 1'b0;
    logic              reset_n;
    logic              bill_valid;
    logic              bill_ready;
    logic [WIDTH-1:0]  bill_amount;
    logic              coin_valid;
    logic              coin_ready;
    logic [COIN_W-1:0] coin_value;
    logic              cancel;
    logic              res_valid;
    logic              res_ready;
    logic              res_paid;
    logic [WIDTH:0]    res_amount;
    logic              busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    fcims_payment_collector #(
        .WIDTH   (WIDTH),
        .COIN_W  (COIN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bill_valid  (bill_valid),
        .bill_ready  (bill_ready),
        .bill_amount (bill_amount),
        .coin_valid  (coin_valid),
        .coin_ready  (coin_ready),
        .coin_value  (coin_value),
        .cancel      (cancel),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_paid    (res_paid),
        .res_amount  (res_amount),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_bill(input logic [WIDTH-1:0] amt);
        check("bill_ready_before_offer", {31'd0, bill_ready}, 32'd1);
        bill_valid  = 1'b1;
        bill_amount = amt;
        tick();
        bill_valid  = 1'b0;
        bill_amount = '0;
    endtask

    task automatic insert_coin(input logic [COIN_W-1:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    // Waits (bounded) for a result, then completes one handshake.
    task automatic take_result();
        int n;
        n = 0;
        while (!res_valid && n < 50) begin
            tick();
            n++;
        end
        check("res_valid_wait", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // Bill 30, coin 12, then idle; optionally a zero coin on idle cycle 10.
    task automatic timeout_run(input bit zero_coin);
        int fire;
        exp_q.push_back({1'b1 & 1'b0, 9'd12});
        offer_bill(8'd30);
        insert_coin(4'd12);
        fire = 0;
        for (int i = 1; i <= 30; i++) begin
            if (zero_coin && i == 10) begin
                coin_valid = 1'b1;
                coin_value = '0;
            end
            tick();
            coin_valid = 1'b0;
            if (res_valid) begin
                fire = i;
                break;
            end
        end
        // Timer is 0 after the coin edge and fires on the edge where it holds TIMEOUT-1.
        check(zero_coin ? "timeout_cycle_zero_coin" : "timeout_cycle", fire, TIMEOUT);
        check("timeout_is_refund", {31'd0, res_paid}, 32'd0);
        take_result();
    endtask

    // Monitor: compares every accepted result against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got paid=%0d amount=%0d expected none",
                             res_paid, res_amount);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {22'd0, res_paid, res_amount}, {22'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_n     = 1'b0;
        bill_valid  = 1'b0;
        bill_amount = '0;
        coin_valid  = 1'b0;
        coin_value  = '0;
        cancel      = 1'b0;
        res_ready   = 1'b0;
        repeat (2) tick();
        // {bill_ready, coin_ready, res_valid, res_paid, res_amount, busy}
        check("reset_outputs", {bill_ready, coin_ready, res_valid, res_paid, res_amount, busy},
              {1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0});
        reset_n = 1'b1;
        tick();

        // Exact pay: 25 = 10 + 10 + 5.
        exp_q.push_back({1'b1, 9'd0});
        offer_bill(8'd25);
        check("collect_entry", {busy, coin_ready, bill_ready}, 3'b110);
        insert_coin(4'd10);
        insert_coin(4'd10);
        check("exact_no_early_result", {31'd0, res_valid}, 32'd0);
        insert_coin(4'd5);
        check("exact_latency", {31'd0, res_valid}, 32'd1);
        take_result();
        check("idle_after_ready", {busy, bill_ready, res_valid}, 3'b010);

        // Overpay: 14 x 15 = 210 against 200 -> change 10.
        exp_q.push_back({1'b1, 9'd10});
        offer_bill(8'd200);
        for (int i = 0; i < 13; i++) insert_coin(4'd15);
        check("overpay_pending", {res_valid, coin_ready}, 2'b01);
        insert_coin(4'd15);
        check("overpay_latency", {31'd0, res_valid}, 32'd1);
        coin_valid = 1'b1;
        coin_value = 4'd15;
        check("coin_ready_in_change", {31'd0, coin_ready}, 32'd0);
        tick();
        coin_valid = 1'b0;
        coin_value = '0;
        for (int i = 0; i < 2; i++) begin
            check("change_hold", {res_valid, res_paid, res_amount}, {1'b1, 1'b1, 9'd10});
            tick();
        end
        take_result();

        // Cancel together with a coin: 7 + 8 + 9 = 24 refunded.
        exp_q.push_back({1'b0, 9'd24});
        offer_bill(8'd50);
        insert_coin(4'd7);
        insert_coin(4'd8);
        cancel = 1'b1;
        insert_coin(4'd9);
        cancel = 1'b0;
        check("cancel_latency", {res_valid, res_paid}, 2'b10);
        take_result();

        // Cancel beats a coin that would have settled the bill.
        exp_q.push_back({1'b0, 9'd15});
        offer_bill(8'd10);
        cancel = 1'b1;
        insert_coin(4'd15);
        cancel = 1'b0;
        take_result();

        // Timeout, then the same with a zero-value coin mid-wait.
        timeout_run(1'b0);
        timeout_run(1'b1);

        // Zero bill goes straight to CHANGE; hold it under backpressure.
        exp_q.push_back({1'b1, 9'd0});
        offer_bill(8'd0);
        check("zero_bill_latency", {res_valid, res_paid, res_amount}, {1'b1, 1'b1, 9'd0});
        for (int i = 0; i < 5; i++) begin
            check("backpressure_hold", {res_valid, res_paid, res_amount, bill_ready, busy},
                  {1'b1, 1'b1, 9'd0, 1'b0, 1'b1});
            tick();
        end
        take_result();

        // Async reset mid-COLLECT discards the collected coin without a refund.
        offer_bill(8'd90);
        insert_coin(4'd15);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {bill_ready, coin_ready, res_valid, res_paid, res_amount, busy},
              {1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0});
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_reset_idle", {res_valid, bill_ready, busy}, 3'b010);
        end
        exp_q.push_back({1'b1, 9'd2});
        offer_bill(8'd5);
        insert_coin(4'd3);
        insert_coin(4'd4);
        check("post_reset_result", {31'd0, res_valid}, 32'd1);
        take_result();

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fcims_payment_collector
